// File: rtl/rnm_pga_core_if.sv
// Signal bundle between an RNM stimulus/sampler environment and rnm_pga_core.
// Real-valued members carry voltages; the core uses the slave view.
interface rnm_pga_core_if #(
  parameter int GAIN_BITS = 2,
  parameter int CNT_BITS  = 8
);
  logic                 en;
  logic [GAIN_BITS-1:0] amp;
  real                  vdd;
  real                  in;
  real                  out;
  logic                 ready;
  logic                 ovr;
  logic [CNT_BITS-1:0]  clip_cnt;

  modport master (
    output en, amp, vdd, in,
    input  out, ready, ovr, clip_cnt
  );

  modport slave (
    input  en, amp, vdd, in,
    output out, ready, ovr, clip_cnt
  );
endinterface

// File: rtl/rnm_pga_core.sv
// Clocked real-number-model PGA: supply-qualified power-up, settle interval
// after enable or gain change, rail clipping with overrange flag and clip count.
module rnm_pga_core #(
  parameter int  GAIN_BITS     = 2,
  parameter int  SETTLE_CYCLES = 4,
  parameter real VDD_MIN       = 0.5,
  parameter int  CNT_BITS      = 8
) (
  input  logic             sampling_Clk,
  input  logic             rst_n,
  rnm_pga_core_if.slave    pga
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {OFF, SETTLE, ACTIVE} state_t;

  state_t               state_q, state_n;
  logic [SC_W-1:0]      cnt_q, cnt_n;
  logic [GAIN_BITS-1:0] gain_q, gain_n;
  real                  out_q, out_n;
  logic                 ready_q, ready_n;
  logic                 ovr_q, ovr_n;
  logic [CNT_BITS-1:0]  clip_q, clip_n;

  logic supply_ok;
  logic go_off;
  logic amp_chg;
  real  gain_mult;
  real  y;
  real  y_clip;
  logic clipped;

  assign supply_ok = (pga.vdd >= VDD_MIN);
  assign go_off    = !pga.en || !supply_ok;
  assign amp_chg   = (pga.amp != gain_q);

  // Gain is an exact power of two, so the real multiply introduces no rounding.
  always_comb begin
    gain_mult = real'(32'd1 << gain_q);
    y         = pga.in * gain_mult;
    y_clip    = y;
    clipped   = 1'b0;
    if (y > pga.vdd) begin
      y_clip  = pga.vdd;
      clipped = 1'b1;
    end else if (y < -pga.vdd) begin
      y_clip  = -pga.vdd;
      clipped = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_n = state_q;
    cnt_n   = cnt_q;
    gain_n  = gain_q;
    out_n   = out_q;
    ready_n = ready_q;
    ovr_n   = ovr_q;
    clip_n  = clip_q;

    unique case (state_q)
      OFF: begin
        out_n   = 0.0;
        ready_n = 1'b0;
        ovr_n   = 1'b0;
        if (!go_off) begin
          state_n = SETTLE;
          cnt_n   = '0;
          gain_n  = pga.amp;
          clip_n  = '0;
        end
      end

      SETTLE: begin
        ready_n = 1'b0;
        ovr_n   = 1'b0;
        if (go_off) begin
          state_n = OFF;
          out_n   = 0.0;
        end else if (amp_chg) begin
          gain_n = pga.amp;
          cnt_n  = '0;
        end else if (cnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
          state_n = ACTIVE;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      ACTIVE: begin
        if (go_off) begin
          state_n = OFF;
          out_n   = 0.0;
          ready_n = 1'b0;
          ovr_n   = 1'b0;
        end else if (amp_chg) begin
          state_n = SETTLE;
          gain_n  = pga.amp;
          cnt_n   = '0;
          ready_n = 1'b0;
          ovr_n   = 1'b0;
        end else begin
          out_n = y_clip;
          ovr_n = clipped;
          if (clipped && (clip_q != {CNT_BITS{1'b1}}))
            clip_n = clip_q + 1'b1;
        end
      end

      default: begin
        state_n = OFF;
        out_n   = 0.0;
        ready_n = 1'b0;
        ovr_n   = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge sampling_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      gain_q  <= '0;
      out_q   <= 0.0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      clip_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      gain_q  <= gain_n;
      out_q   <= out_n;
      ready_q <= ready_n;
      ovr_q   <= ovr_n;
      clip_q  <= clip_n;
    end
  end

  assign pga.out      = out_q;
  assign pga.ready    = ready_q;
  assign pga.ovr      = ovr_q;
  assign pga.clip_cnt = clip_q;

endmodule

// File: tb/tb_rnm_pga_core.sv
// Directed self-checking bench for rnm_pga_core (CNT_BITS=2 so the clip
// counter saturates within a short sequence).
module tb_rnm_pga_core;

  localparam int GB = 2;
  localparam int CB = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  rnm_pga_core_if #(.GAIN_BITS(GB), .CNT_BITS(CB)) pga ();

  rnm_pga_core #(
    .GAIN_BITS    (GB),
    .SETTLE_CYCLES(4),
    .VDD_MIN      (0.5),
    .CNT_BITS     (CB)
  ) dut (
    .sampling_Clk(clk),
    .rst_n       (rst_n),
    .pga         (pga.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CB-1:0] obs,
                           input logic [CB-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_real(input string tag, input real obs, input real exp);
    real d;
    d = obs - exp;
    if (d < 0.0) d = -d;
    tests++;
    assert (d < 1.0e-9)
    else begin
      fails++;
      $error("FAIL %s: got %f, want %f", tag, obs, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b1;
    pga.en    = 1'b1;
    pga.amp   = '0;
    pga.vdd   = 1.0;
    pga.in    = 0.7;

    // Reset asserted between edges
    #1 rst_n = 1'b0;
    #1;
    check_real("rst_out", pga.out, 0.0);
    check_bit("rst_ready", pga.ready, 1'b0);
    check_bit("rst_ovr", pga.ovr, 1'b0);
    check_cnt("rst_clip", pga.clip_cnt, 2'd0);
    tick(2);
    check_real("rst_hold_out", pga.out, 0.0);
    check_bit("rst_hold_ready", pga.ready, 1'b0);

    // Power-up at unity gain
    pga.in = 0.25;
    rst_n  = 1'b1;
    tick(1);
    check_bit("pu_k_ready", pga.ready, 1'b0);
    tick(3);
    check_bit("pu_k3_ready", pga.ready, 1'b0);
    tick(1);
    check_bit("pu_k4_ready", pga.ready, 1'b1);
    check_real("pu_k4_out", pga.out, 0.0);
    tick(1);
    check_real("pu_k5_out", pga.out, 0.25);
    check_bit("pu_k5_ovr", pga.ovr, 1'b0);

    // Gain 8 and rail clipping
    pga.amp = 2'd3;
    pga.in  = 0.1;
    tick(1);
    check_bit("g3_settle_ready", pga.ready, 1'b0);
    check_real("g3_settle_out", pga.out, 0.25);
    tick(3);
    check_bit("g3_settle3_ready", pga.ready, 1'b0);
    tick(1);
    check_bit("g3_active_ready", pga.ready, 1'b1);
    tick(1);
    check_real("g3_in01_out", pga.out, 0.8);
    check_bit("g3_in01_ovr", pga.ovr, 1'b0);
    check_cnt("g3_in01_clip", pga.clip_cnt, 2'd0);
    pga.in = 0.2;
    tick(1);
    check_real("g3_in02_out", pga.out, 1.0);
    check_bit("g3_in02_ovr", pga.ovr, 1'b1);
    check_cnt("g3_in02_clip", pga.clip_cnt, 2'd1);
    pga.in = -0.3;
    tick(1);
    check_real("g3_inm03_out", pga.out, -1.0);
    check_bit("g3_inm03_ovr", pga.ovr, 1'b1);
    check_cnt("g3_inm03_clip", pga.clip_cnt, 2'd2);
    pga.in = 0.125;
    tick(1);
    check_real("g3_rail_out", pga.out, 1.0);
    check_bit("g3_rail_ovr", pga.ovr, 1'b0);
    check_cnt("g3_rail_clip", pga.clip_cnt, 2'd2);

    // Gain change 1 -> 2 in ACTIVE, with a restart during SETTLE
    pga.amp = 2'd1;
    pga.in  = 0.25;
    tick(5);
    check_bit("g1_ready", pga.ready, 1'b1);
    tick(1);
    check_real("g1_out", pga.out, 0.5);
    pga.amp = 2'd2;
    tick(1);
    check_bit("g2_chg_ready", pga.ready, 1'b0);
    check_real("g2_chg_out", pga.out, 0.5);
    tick(2);
    pga.amp = 2'd3;
    tick(1);
    pga.amp = 2'd2;
    tick(1);
    check_real("g2_toggle_out", pga.out, 0.5);
    tick(3);
    check_bit("g2_restart_ready", pga.ready, 1'b0);
    tick(1);
    check_bit("g2_active_ready", pga.ready, 1'b1);
    check_real("g2_active_out", pga.out, 0.5);
    tick(1);
    check_real("g2_out", pga.out, 1.0);
    check_bit("g2_ovr", pga.ovr, 1'b0);

    // Supply loss and recovery
    pga.vdd = 0.3;
    tick(1);
    check_real("vlow_out", pga.out, 0.0);
    check_bit("vlow_ready", pga.ready, 1'b0);
    check_cnt("vlow_clip", pga.clip_cnt, 2'd2);
    tick(3);
    check_bit("vlow_stay_ready", pga.ready, 1'b0);
    pga.vdd = 1.0;
    tick(1);
    check_cnt("vok_clip_clr", pga.clip_cnt, 2'd0);
    tick(3);
    check_bit("vok_settle_ready", pga.ready, 1'b0);
    tick(1);
    check_bit("vok_ready", pga.ready, 1'b1);

    // Enable drop mid-SETTLE
    pga.amp = 2'd0;
    tick(2);
    pga.en = 1'b0;
    tick(1);
    check_real("en_off_out", pga.out, 0.0);
    pga.en = 1'b1;
    tick(4);
    check_bit("en_resettle_ready", pga.ready, 1'b0);
    tick(1);
    check_bit("en_active_ready", pga.ready, 1'b1);
    tick(1);
    check_real("en_active_out", pga.out, 0.25);

    // Simultaneous en drop and amp change: OFF wins
    pga.en  = 1'b0;
    pga.amp = 2'd1;
    tick(1);
    check_real("en_amp_out", pga.out, 0.0);
    check_bit("en_amp_ready", pga.ready, 1'b0);

    // Clip counter saturation
    pga.en  = 1'b1;
    pga.amp = 2'd3;
    pga.in  = 0.5;
    tick(5);
    check_bit("sat_ready", pga.ready, 1'b1);
    check_cnt("sat_clr", pga.clip_cnt, 2'd0);
    tick(1);
    check_cnt("sat_c1", pga.clip_cnt, 2'd1);
    check_real("sat_out", pga.out, 1.0);
    tick(4);
    check_cnt("sat_c5", pga.clip_cnt, 2'd3);
    check_bit("sat_ovr", pga.ovr, 1'b1);

    // Async reset between edges in ACTIVE
    #3 rst_n = 1'b0;
    #1;
    check_real("arst_out", pga.out, 0.0);
    check_bit("arst_ready", pga.ready, 1'b0);
    check_bit("arst_ovr", pga.ovr, 1'b0);
    check_cnt("arst_clip", pga.clip_cnt, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rnm_pga_core.md
Name: rnm_pga_core

Overview:
- Parametrised, clocked real-number-model programmable-gain amplifier; next generation of the 2-bit RNM amplifier.
- Adds supply-qualified power-up sequencing, a settling interval after enable or gain change, rail clipping with an overrange flag, and a saturating clip counter.
- Sits between RNM stimulus sources (sine generators) and downstream RNM samplers/ADC models.
- Compiled with iverilog -m va_math; real-valued ports carry voltages.

Parameters:
- GAIN_BITS, 2: width of gain code; gain = 2^amp (amp=0 gives unity).
- SETTLE_CYCLES, 4: clock cycles spent in SETTLE before output is valid; minimum 1.
- VDD_MIN, 0.5 (real): minimum supply for operation, in volts.
- CNT_BITS, 8: width of the clip counter.

Ports:
- sampling_Clk  input  1  sampling clock; rising edge only.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable.
- amp  input  GAIN_BITS  gain code.
- vdd  input  real  supply voltage; also sets the clip rails ±vdd.
- in  input  real  analog input.
- out  output  real  registered amplified output.
- ready  output  1  high while in ACTIVE.
- ovr  output  1  high for each cycle in which the registered sample was clipped.
- clip_cnt  output  CNT_BITS  number of clipped samples since leaving OFF; saturates.

Behaviour:
- One clock, sampling_Clk, rising edge only. Reset is asynchronous and active-low (rst_n).
- rst_n low: state=OFF, out=0.0, ready=0, ovr=0, clip_cnt=0, settle counter=0, latched gain=0. This takes effect immediately, including mid-SETTLE or mid-ACTIVE.
- supply_ok is defined as (vdd >= VDD_MIN) and is evaluated at each edge.
- States are OFF, SETTLE and ACTIVE.
- OFF:
  - out=0.0, ready=0, ovr=0.
  - On an edge with en=1 and supply_ok: go to SETTLE, settle counter=0, latch amp, clear clip_cnt.
- SETTLE:
  - ready=0, ovr=0. out holds its last value (0.0 when entered from OFF).
  - Each edge:
    - en=0 or !supply_ok: go to OFF; out=0.0.
    - Otherwise, if amp differs from the latched gain: relatch amp; counter=0.
    - Otherwise, if counter==SETTLE_CYCLES-1: go to ACTIVE; ready=1; out unchanged.
    - Otherwise: counter+1.
  - SETTLE therefore spans exactly SETTLE_CYCLES edges after entry when amp is stable.
- ACTIVE:
  - Each edge:
    - en=0 or !supply_ok: go to OFF; out=0.0, ready=0, ovr=0. clip_cnt holds its value.
    - Otherwise, if amp differs from the latched gain: go to SETTLE; relatch amp; counter=0; ready=0; ovr=0; out holds.
    - Otherwise: y = in * 2^gain. out = min(max(y, -vdd), +vdd). ovr=1 when |y| > vdd. clip_cnt+1 on clip, holding at 2^CNT_BITS-1.
  - Latency: one edge from in to out.
- Arithmetic: gain is formed as a real power of two from the unsigned code. No rounding or quantisation of out.
- Boundary cases:
  - |y| == vdd is not a clip (ovr=0).
  - vdd == VDD_MIN counts as supply_ok.
  - Simultaneous en drop and amp change: OFF wins.
  - Priority order at each edge: rst_n, then en/supply, then amp change, then settle/sample.
- in and vdd are sampled only at edges; no events between edges affect out.

Test Plan:
- Reset: rst_n=0 with vdd=1, en=1, in=0.7 -> out=0.0, ready=0, ovr=0, clip_cnt=0. These values hold until the first edge after rst_n rises.
- Power-up: vdd=1, en=1, amp=0, in=0.25; first qualifying edge k -> ready=1 after edge k+4, out still 0.0. At edge k+5, out=0.25, ovr=0.
- Gain and clip (amp=3), each stimulus applied in ACTIVE after a re-settle:
  - in=0.1 -> out=0.8, ovr=0.
  - in=0.2 -> out=1.0, ovr=1, clip_cnt=1.
  - in=-0.3 -> out=-1.0, ovr=1, clip_cnt=2.
  - in=0.125 -> out=1.0, ovr=0 (exact rail).
- Gain change in ACTIVE: amp 1 -> 2 with out=0.5 -> ready=0 for 4 edges, out held at 0.5. Then ready=1, and the next edge gives out=2*2^... i.e. in*4, per the new gain. Toggling amp again during SETTLE restarts the 4-cycle count.
- Supply and enable loss:
  - vdd drops to 0.3 in ACTIVE -> next edge OFF, out=0.0, ready=0, clip_cnt retained.
  - vdd back to 1.0 -> full SETTLE_CYCLES sequence again, clip_cnt cleared.
  - en=0 mid-SETTLE -> OFF.
- Saturation and async reset: CNT_BITS=2 with 5 consecutive clipped samples -> clip_cnt=3. Asserting rst_n between edges during ACTIVE -> out=0.0 and ready=0 immediately, without waiting for a clock edge.
